// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect from PC/branch logic, and the valid/ready channel towards decode.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    // memory / branch logic / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order word fetch with a prefetch queue of
// {pc, instr}, credit-based issue so the queue can never overflow, and
// redirect handling that flushes the queue and drops stale in-flight responses.
module fetch_unit #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(QDEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   pc_fifo [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, pf_wr, pf_rd;
    logic [CW-1:0] count, live, stale;
    logic [CW+1:0] used;
    logic          req_valid, head_valid;
    logic          accept, pop, rsp_drop, rsp_keep;
    logic          unused_redirect_lsbs;

    // Every outstanding request, kept or stale, holds a credit so that a
    // live response always finds a free queue slot.
    assign used       = {2'b00, count} + {2'b00, live} + {2'b00, stale};
    assign req_valid  = !rst && (used < DEPTH_W);
    assign head_valid = (count != '0);

    assign accept   = req_valid && bus.imem_req_ready;
    assign pop      = head_valid && bus.instr_ready;
    assign rsp_drop = bus.imem_rsp_valid && (stale != '0);
    assign rsp_keep = bus.imem_rsp_valid && (stale == '0) && (live != '0);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = head_valid;
    assign bus.instr_data     = q_instr[rd_ptr];
    assign bus.instr_pc       = q_pc[rd_ptr];

    // Low address bits of a redirect target are forced to zero.
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Issue, response capture, dequeue and redirect flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pf_wr    <= '0;
            pf_rd    <= '0;
            count    <= '0;
            live     <= '0;
            stale    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            if (accept) begin
                pc_fifo[pf_wr] <= fetch_pc;
                pf_wr          <= pf_wr + AW'(1);
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (bus.redirect_valid) begin
                // Everything still in flight, including a request accepted
                // this cycle, becomes stale; a response this cycle is retired.
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                pf_wr    <= '0;
                pf_rd    <= '0;
                count    <= '0;
                live     <= '0;
                stale    <= stale + live + CW'(accept) - CW'(rsp_drop | rsp_keep);
            end else begin
                if (rsp_keep) begin
                    q_pc[wr_ptr]    <= pc_fifo[pf_rd];
                    q_instr[wr_ptr] <= bus.imem_rsp_data;
                    wr_ptr          <= wr_ptr + AW'(1);
                    pf_rd           <= pf_rd + AW'(1);
                end
                count <= count + CW'(rsp_keep) - CW'(pop);
                live  <= live + CW'(accept) - CW'(rsp_keep);
                stale <= stale - CW'(rsp_drop);
            end
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    always_ff @(posedge clk) begin
        if (!rst && bus.imem_rsp_valid)
            assert (live != '0 || stale != '0);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-level model of the fetch stage (what must be
// at the decode head, which address must be offered, how much credit is
// outstanding) checked every cycle, plus directed scenarios with literal
// expectations on the issued and delivered PC streams.
module tb_fetch_unit;
    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_unit_if bus();

    fetch_unit #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mem_lat = 1;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] addr; bit killed; } infl_t;

    mreq_t       mem_q[$];     // memory: accepted requests awaiting response
    infl_t       m_infl[$];    // model: outstanding requests, killed if redirected
    logic [31:0] m_q[$];       // model: PCs waiting at decode
    logic [31:0] m_fetch_pc;
    logic [31:0] acc_log[$];   // every accepted request address
    logic [31:0] got_log[$];   // every PC consumed by decode
    int          first_acc, first_iv;

    bit          m_rv, ev_acc, ev_pop, ev_rsp, ev_redir, ev_keep;
    infl_t       ev_e;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: in-order responses once each request's latency elapses.
    always @(posedge clk) begin
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfn(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    // Compare DUT outputs with the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            m_q.delete();
            m_infl.delete();
            mem_q.delete();
            m_fetch_pc = RPC;
            first_acc  = -1;
            first_iv   = -1;
        end else begin
            m_rv = (m_q.size() + m_infl.size()) < QD;
            chk("req_valid", 32'(bus.imem_req_valid), 32'(m_rv));
            chk("req_addr", bus.imem_req_addr, m_fetch_pc);
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("instr_pc", bus.instr_pc, m_q[0]);
                chk("instr_data", bus.instr_data, memfn(m_q[0]));
            end
            ev_acc   = m_rv && bus.imem_req_ready;
            ev_pop   = (m_q.size() > 0) && bus.instr_ready;
            ev_rsp   = bus.imem_rsp_valid;
            ev_redir = bus.redirect_valid;
            ev_keep  = 1'b0;
            if (ev_acc && first_acc < 0) first_acc = cyc;
            if (bus.instr_valid && first_iv < 0) first_iv = cyc;
            if (ev_rsp && m_infl.size() > 0) begin
                ev_e    = m_infl.pop_front();
                ev_keep = !ev_e.killed && !ev_redir;
            end
            if (ev_pop) begin
                got_log.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (ev_keep) m_q.push_back(ev_e.addr);
            if (ev_acc) begin
                m_infl.push_back('{m_fetch_pc, 1'b0});
                mem_q.push_back('{cyc + mem_lat, m_fetch_pc});
                acc_log.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (ev_redir) begin
                m_q.delete();
                foreach (m_infl[i]) m_infl[i].killed = 1'b1;
                m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
            end
        end
    end

    // Hold reset for two edges, check reset values, release at posedge+1.
    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #4;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, RPC);
        chk("rst_instr_data", bus.instr_data, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        @(posedge clk);
        #1;
        acc_log.delete();
        got_log.delete();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int mark, n_old, n_12;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b1;

        // Streaming with a 1-cycle memory
        mem_lat = 1;
        reset_dut();
        run(4);
        mark = got_log.size();
        run(8);
        chk("throughput_8cyc", 32'(got_log.size() - mark), 32'd8);
        chk("s1_acc0", qget(acc_log, 0), 32'h0);
        chk("s1_acc1", qget(acc_log, 1), 32'h4);
        chk("s1_acc2", qget(acc_log, 2), 32'h8);
        chk("s1_got0", qget(got_log, 0), 32'h0);
        chk("s1_got1", qget(got_log, 1), 32'h4);
        chk("s1_got2", qget(got_log, 2), 32'h8);
        chk("first_valid_latency", 32'(first_iv - first_acc), 32'd2);

        // Decode stalled: credit stops issue at QDEPTH, then drain
        bus.instr_ready = 1'b0;
        reset_dut();
        run(10);
        chk("accepted_when_full", 32'(acc_log.size()), 32'd4);
        #3;
        chk("req_valid_full", 32'(bus.imem_req_valid), 32'h0);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        run(10);
        chk("s2_got0", qget(got_log, 0), 32'h0);
        chk("s2_got1", qget(got_log, 1), 32'h4);
        chk("s2_got2", qget(got_log, 2), 32'h8);
        chk("s2_got3", qget(got_log, 3), 32'hC);
        chk("s2_resume", qget(acc_log, 4), 32'h10);

        // Memory not ready for 3 cycles: address holds
        reset_dut();
        run(2);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("stall_addr", bus.imem_req_addr, 32'h8);
            chk("stall_valid", 32'(bus.imem_req_valid), 32'h1);
            @(posedge clk);
            #1;
        end
        bus.imem_req_ready = 1'b1;
        run(4);
        chk("s3_acc2", qget(acc_log, 2), 32'h8);
        chk("s3_acc3", qget(acc_log, 3), 32'hC);

        // Redirect with two 3-cycle requests in flight
        mem_lat = 3;
        reset_dut();
        run(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        bus.imem_req_ready = 1'b0;
        run(1);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        run(15);
        chk("s4_got0", qget(got_log, 0), 32'h100);
        chk("s4_got1", qget(got_log, 1), 32'h104);
        chk("s4_acc2", qget(acc_log, 2), 32'h100);
        n_old = 0;
        foreach (got_log[i]) if (got_log[i] < 32'h100) n_old++;
        chk("s4_old_pc_leak", 32'(n_old), 32'd0);

        // Redirect coinciding with response, accept and dequeue
        mem_lat = 1;
        reset_dut();
        run(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        run(1);
        bus.redirect_valid = 1'b0;
        #3;
        chk("s5_flush_valid", 32'(bus.instr_valid), 32'h0);
        chk("s5_target_addr", bus.imem_req_addr, 32'h200);
        chk("s5_target_valid", 32'(bus.imem_req_valid), 32'h1);
        @(posedge clk);
        #1;
        run(8);
        chk("s5_got3", qget(got_log, 3), 32'hC);
        chk("s5_got4", qget(got_log, 4), 32'h200);
        chk("s5_acc6", qget(acc_log, 6), 32'h200);
        n_12 = 0;
        foreach (got_log[i]) if (got_log[i] == 32'hC) n_12++;
        chk("s5_consumed_once", 32'(n_12), 32'd1);

        // Redirect to an unaligned top-of-memory address: wrap to 0
        reset_dut();
        run(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        run(1);
        bus.redirect_valid = 1'b0;
        run(8);
        chk("s6_acc2", qget(acc_log, 2), 32'hFFFF_FFFC);
        chk("s6_acc3", qget(acc_log, 3), 32'h0);
        chk("s6_got0", qget(got_log, 0), 32'hFFFF_FFFC);
        chk("s6_got1", qget(got_log, 1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the riscv_pkg core, sitting directly upstream of instruction decode. It issues in-order word reads to instruction memory through a valid/ready request channel and buffers returned instructions with their PCs in a prefetch queue. It presents them to decode through a valid/ready handshake. A redirect input from the PC/branch logic flushes the queue, discards stale in-flight responses, and restarts fetch at the new target.

## Interface
- QDEPTH, 4, prefetch queue entries and the maximum number of in-flight requests; power of two, at least 2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  word address of the request (bits [1:0] always 0)
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after acceptance, never back-pressured
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] are ignored (forced to 0)
- instr_valid  out  1  queue head valid
- instr_data  out  32  instruction at queue head
- instr_pc  out  32  PC of the instruction at queue head
- instr_ready  in  1  decode consumes the head this cycle

## Operation
- Registers: fetch_pc; queue of {pc, instr} with wr/rd pointers and count; pc FIFO of in-flight addresses; live counter (in-flight responses to keep); stale counter (in-flight responses to drop).
- Issue: imem_req_valid = !rst && (count + live + stale < QDEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready): push fetch_pc into the pc FIFO, live += 1, fetch_pc += 4. The PC wraps from 32'hFFFF_FFFC to 0.
- Address stability: while valid && !ready, imem_req_addr holds. The only exception is redirect.
- Response: if stale > 0, the response is dropped and stale -= 1. Otherwise it is written to the queue with its PC popped from the pc FIFO, and live -= 1.
- Dequeue: on instr_valid && instr_ready, the head is popped. instr_valid = (count != 0). Outputs come directly from the head entry.
- Redirect in cycle N, with all effects visible at cycle N+1:
  - The queue is emptied and the pc FIFO is cleared.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - stale = stale + live + (request accepted in N) - (response arrived in N), and live = 0.
- Simultaneous events in the redirect cycle:
  - A dequeue in cycle N still completes; decode has consumed that instruction.
  - A response in cycle N is counted against stale/live and is never enqueued.
  - A request accepted in cycle N becomes stale.
- A full queue never overflows: the credit rule reserves a slot for every live response.
- Simultaneous push and pop leaves count unchanged.
- Counter widths are $clog2(QDEPTH)+1 bits.
- A response arriving while live == 0 and stale == 0 is a protocol error. It is ignored and the block asserts in simulation.

## Timing
- Reset values: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr_data=0, instr_pc=0, count=live=stale=0.
- First request: the first cycle after rst deasserts, with addr RESET_PC.
- Back-to-back issue is possible: one request per cycle while credit is available.
- Response to decode latency: a response in cycle N gives instr_valid in cycle N+1, provided the queue was empty or the entry is next in order.
- Redirect in cycle N:
  - instr_valid=0 in cycle N+1.
  - The first request to the target is presented in cycle N+1.
- Reset mid-operation: all counters, queue, and pc FIFO clear in one cycle. Memory responses to pre-reset requests must not arrive after reset; this is an environment requirement.
- With a 1-cycle memory and instr_ready held at 1, the steady-state throughput is 1 instruction per cycle.

## Test plan
- Reset release, memory with always-ready and 1-cycle latency, instr_ready=1 -> requests at 0,4,8,… on consecutive cycles; instr_pc 0,4,8 with matching data; instr_valid first high 2 cycles after the first request.
- instr_ready=0, QDEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0. Raise instr_ready -> PCs 0,4,8,12 drain in order and issue resumes at 16.
- imem_req_ready=0 for 3 cycles -> imem_req_addr held at the same value and fetch_pc not advanced.
- With 2 requests in flight (variable 3-cycle latency), redirect to 0x100 -> both old responses dropped; next instr_pc=0x100, then 0x104; no old-PC instruction ever valid.
- Redirect coinciding with a response, a request accept, and a dequeue -> the dequeued instruction is consumed once, the response is dropped, the accepted request is counted stale, and the queue is empty next cycle.
- Redirect with redirect_pc=0xFFFF_FFFE -> first fetch at 0xFFFF_FFFC, then 0x0000_0000 (wrap).
